// File: rtl/password_mode_select_if.sv
// Switch/LED/mode bundle between the board pins and password_mode_select.
// The lock signal exists only when PW_MODE_LOCK_EN is defined.
interface password_mode_select_if;
    logic [15:0] sw;
    logic [2:0]  mode;
    logic        mode_change;
    logic [15:0] led;
`ifdef PW_MODE_LOCK_EN
    logic        lock;
`endif

    // Handshake: there is no valid/ready pair. sw is a level that is sampled
    // every clock. mode is a level. mode_change acts as a one-clock valid that
    // marks a committed change of mode, and it has no back-pressure.
`ifdef PW_MODE_LOCK_EN
    modport master (output sw, output lock, input mode, input mode_change, input led);
    modport slave  (input sw, input lock, output mode, output mode_change, output led);
`else
    modport master (output sw, input mode, input mode_change, input led);
    modport slave  (input sw, output mode, output mode_change, output led);
`endif
endinterface

// File: rtl/password_mode_select.sv
// Synchronises and debounces the slide switches, decodes them into a task mode, and drives the LEDs.
// Optional macro PW_MODE_LOCK_EN adds a lock input that freezes mode commits.
module password_mode_select #(
    parameter int          STABLE_CYCLES = 1000000,
    parameter int          SLOW_HALF     = 8333333,
    parameter int          FAST_HALF     = 5000000,
    parameter logic [15:0] PW_A          = 16'h0279,
    parameter logic [15:0] PW_B          = 16'h02A5,
    parameter logic [15:0] PW_C          = 16'h4345,
    parameter logic [15:0] PW_D          = 16'h82AD
) (
    input  logic                   basys_clock,
    input  logic                   reset,
    password_mode_select_if.slave  bus
);
    localparam int CNT_W  = $clog2(STABLE_CYCLES + 1);
    localparam int SLOW_W = $clog2(SLOW_HALF + 1);
    localparam int FAST_W = $clog2(FAST_HALF + 1);

    localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(STABLE_CYCLES);
    localparam logic [CNT_W-1:0]  CNT_PRE   = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [SLOW_W-1:0] SLOW_WRAP = SLOW_W'(SLOW_HALF - 1);
    localparam logic [FAST_W-1:0] FAST_WRAP = FAST_W'(FAST_HALF - 1);

    // The state encoding is the mode value itself.
    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] TASK_A = 3'd1;
    localparam logic [2:0] TASK_B = 3'd2;
    localparam logic [2:0] TASK_C = 3'd3;
    localparam logic [2:0] TASK_D = 3'd4;

    logic [15:0]       s1_q, s2_q, last_q, last_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [2:0]        mode_q, mode_d, decode;
    logic              mode_change_q, mode_change_d;
    logic              commit;
    logic [SLOW_W-1:0] slow_q, slow_d;
    logic [FAST_W-1:0] fast_q, fast_d;
    logic              slow_ph_q, slow_ph_d, fast_ph_q, fast_ph_d;
    logic [15:0]       led_q, led_d;
    logic [9:0]        pat;
    logic              ph;
`ifdef PW_MODE_LOCK_EN
    logic              lock_q;
`endif

    always_comb begin
        decode = IDLE;
        if      (last_q == PW_A) decode = TASK_A;
        else if (last_q == PW_B) decode = TASK_B;
        else if (last_q == PW_C) decode = TASK_C;
        else if (last_q == PW_D) decode = TASK_D;
    end

    always_comb begin
        last_d = last_q;
        cnt_d  = cnt_q;
        if (s2_q != last_q) begin
            last_d = s2_q;
            cnt_d  = '0;
        end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // A commit suppressed by lock is taken later, on the first unlocked edge that sees a saturated count.
`ifdef PW_MODE_LOCK_EN
    assign commit = (s2_q == last_q) && !bus.lock &&
                    ((cnt_q == CNT_PRE) || ((cnt_q == CNT_MAX) && lock_q));
`else
    assign commit = (s2_q == last_q) && (cnt_q == CNT_PRE);
`endif

    assign mode_d        = commit ? decode : mode_q;
    assign mode_change_d = commit && (decode != mode_q);

    always_comb begin
        slow_d    = slow_q + 1'b1;
        slow_ph_d = slow_ph_q;
        fast_d    = fast_q + 1'b1;
        fast_ph_d = fast_ph_q;
        if (mode_change_d) begin
            slow_d    = '0;
            slow_ph_d = 1'b1;
            fast_d    = '0;
            fast_ph_d = 1'b1;
        end else begin
            if (slow_q == SLOW_WRAP) begin
                slow_d    = '0;
                slow_ph_d = ~slow_ph_q;
            end
            if (fast_q == FAST_WRAP) begin
                fast_d    = '0;
                fast_ph_d = ~fast_ph_q;
            end
        end
    end

    always_comb begin
        pat = '0;
        ph  = 1'b0;
        case (mode_q)
            TASK_A:  begin pat = PW_A[9:0]; ph = slow_ph_q; end
            TASK_B:  begin pat = PW_B[9:0]; ph = fast_ph_q; end
            TASK_C:  begin pat = PW_C[9:0]; ph = fast_ph_q; end
            TASK_D:  begin pat = PW_D[9:0]; ph = slow_ph_q; end
            default: begin pat = '0;        ph = 1'b0;      end
        endcase
        // In idle, the LEDs echo the synchronised but undebounced switches.
        led_d = (mode_q == IDLE) ? s2_q : {6'b0, pat & {10{ph}}};
    end

    always_ff @(posedge basys_clock) begin
        if (reset) begin
            s1_q          <= '0;
            s2_q          <= '0;
            last_q        <= '0;
            cnt_q         <= '0;
            mode_q        <= IDLE;
            mode_change_q <= 1'b0;
            slow_q        <= '0;
            fast_q        <= '0;
            slow_ph_q     <= 1'b1;
            fast_ph_q     <= 1'b1;
            led_q         <= '0;
        end else begin
            s1_q          <= bus.sw;
            s2_q          <= s1_q;
            last_q        <= last_d;
            cnt_q         <= cnt_d;
            mode_q        <= mode_d;
            mode_change_q <= mode_change_d;
            slow_q        <= slow_d;
            fast_q        <= fast_d;
            slow_ph_q     <= slow_ph_d;
            fast_ph_q     <= fast_ph_d;
            led_q         <= led_d;
        end
    end

`ifdef PW_MODE_LOCK_EN
    always_ff @(posedge basys_clock) begin
        if (reset) lock_q <= 1'b0;
        else       lock_q <= bus.lock;
    end
`endif

    assign bus.mode        = mode_q;
    assign bus.mode_change = mode_change_q;
    assign bus.led         = led_q;
endmodule

// File: tb/tb_password_mode_select.sv
// Directed bench for password_mode_select with small divider parameters.
// Expected mode_change pulses (cycle, mode) are queued and a negedge monitor checks them.
module tb_password_mode_select;
    localparam int W = 35;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    password_mode_select_if bus ();

    password_mode_select #(
        .STABLE_CYCLES(8),
        .SLOW_HALF    (6),
        .FAST_HALF    (4)
    ) dut (
        .basys_clock(clk),
        .reset      (reset),
        .bus        (bus)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    logic [W-1:0] exp_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: each mode_change pulse must match the next queued (cycle, mode).
    always @(negedge clk) begin
        logic [W-1:0] e;
        if (reset === 1'b0 && bus.mode_change === 1'b1) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL spurious_pulse: got mode_change=1 mode=%0d expected no pulse (cycle %0d)", bus.mode, cyc);
            end else begin
                e = exp_q.pop_front();
                check("pulse_cycle", cyc, e[W-1:3]);
                check("pulse_mode", {29'b0, bus.mode}, {29'b0, e[2:0]});
            end
        end
    end

    task automatic wait_cyc(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    task automatic drive_sw(input logic [15:0] v, output int c0);
        @(negedge clk);
        bus.sw = v;
        c0 = cyc;
    endtask

    task automatic push_exp(input int at, input logic [2:0] m);
        logic [31:0] at_v;
        at_v = at;
        exp_q.push_back({at_v, m});
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 64) begin
            @(negedge clk);
            t++;
        end
        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain: got %0d pending pulses expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    logic [15:0] vec_sw   [5] = '{16'h02A5, 16'h02F9, 16'h4345, 16'hC345, 16'h0279};
    logic [2:0]  vec_mode [5] = '{3'd2,     3'd0,     3'd3,     3'd0,     3'd1};
    logic [15:0] vec_led  [5] = '{16'h02A5, 16'h02F9, 16'h0345, 16'hC345, 16'h0279};

    initial begin
        int c, c2, r;
        logic [2:0] cur;
        logic [15:0] exp_led;

        reset  = 1'b1;
        bus.sw = 16'hFFFF;
`ifdef PW_MODE_LOCK_EN
        bus.lock = 1'b0;
`endif
        repeat (3) @(negedge clk);
        check("reset_mode", {29'b0, bus.mode}, 32'd0);
        check("reset_led", {16'b0, bus.led}, 32'd0);
        check("reset_mc", {31'b0, bus.mode_change}, 32'd0);
        reset = 1'b0;
        r = cyc;
        wait_cyc(r + 2);
        check("echo_pre", {16'b0, bus.led}, 32'd0);
        wait_cyc(r + 3);
        check("echo_ffff", {16'b0, bus.led}, 32'h0000FFFF);
        wait_cyc(r + 14);

        // Commit task C and follow the fast blink for two periods.
        drive_sw(16'h4345, c);
        push_exp(c + 11, 3'd3);
        wait_cyc(c + 10);
        check("commit_early", {29'b0, bus.mode}, 32'd0);
        wait_cyc(c + 11);
        check("commit_mode", {29'b0, bus.mode}, 32'd3);
        check("led_at_commit", {16'b0, bus.led}, 32'h00004345);
        for (int i = 1; i <= 16; i++) begin
            wait_cyc(c + 11 + i);
            exp_led = (((i - 1) / 4) % 2 == 0) ? 16'h0345 : 16'h0000;
            check("fast_blink", {16'b0, bus.led}, {16'b0, exp_led});
        end

        // Five-clock glitch to PW_D must not reach mode.
        drive_sw(16'h82AD, c);
        wait_cyc(c + 4);
        drive_sw(16'h4345, c2);
        wait_cyc(c2 + 12);
        check("glitch_mode", {29'b0, bus.mode}, 32'd3);
        wait_cyc(c2 + 20);
        check("glitch_mode_late", {29'b0, bus.mode}, 32'd3);

        drive_sw(16'h1234, c);
        push_exp(c + 11, 3'd0);
        wait_cyc(c + 11);
        check("idle_mode", {29'b0, bus.mode}, 32'd0);
        wait_cyc(c + 13);
        check("idle_echo", {16'b0, bus.led}, 32'h00001234);

        // Task D uses the slow blink.
        drive_sw(16'h82AD, c);
        push_exp(c + 11, 3'd4);
        wait_cyc(c + 11);
        check("slow_mode", {29'b0, bus.mode}, 32'd4);
        for (int i = 1; i <= 18; i++) begin
            wait_cyc(c + 11 + i);
            exp_led = (((i - 1) / 6) % 2 == 0) ? 16'h02AD : 16'h0000;
            check("slow_blink", {16'b0, bus.led}, {16'b0, exp_led});
        end

        cur = 3'd4;
        for (int v = 0; v < 5; v++) begin
            drive_sw(vec_sw[v], c);
            if (vec_mode[v] != cur) push_exp(c + 11, vec_mode[v]);
            cur = vec_mode[v];
            wait_cyc(c + 12);
            check("vec_mode", {29'b0, bus.mode}, {29'b0, vec_mode[v]});
            check("vec_led", {16'b0, bus.led}, {16'b0, vec_led[v]});
        end

        // Reset at cnt = 5 must drop mode without a pulse and restart the count.
        drive_sw(16'h02A5, c);
        wait_cyc(c + 8);
        reset = 1'b1;
        wait_cyc(c + 9);
        check("midrst_mode", {29'b0, bus.mode}, 32'd0);
        check("midrst_mc", {31'b0, bus.mode_change}, 32'd0);
        check("midrst_led", {16'b0, bus.led}, 32'd0);
        reset = 1'b0;
        push_exp(c + 20, 3'd2);
        wait_cyc(c + 19);
        check("count_restart", {29'b0, bus.mode}, 32'd0);
        wait_cyc(c + 20);
        check("after_restart", {29'b0, bus.mode}, 32'd2);

`ifdef PW_MODE_LOCK_EN
        @(negedge clk);
        bus.lock = 1'b1;
        drive_sw(16'h0279, c);
        wait_cyc(c + 20);
        check("lock_hold", {29'b0, bus.mode}, 32'd2);
        @(negedge clk);
        bus.lock = 1'b0;
        c2 = cyc;
        push_exp(c2 + 1, 3'd1);
        wait_cyc(c2 + 1);
        check("lock_release", {29'b0, bus.mode}, 32'd1);
`endif

        drain();
        wait_cyc(cyc + 4);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no completion expected finish within 20000 cycles");
        $fatal(1, "timeout");
    end
endmodule
